// File: rtl/vu_pkg.sv
// Shared types, defaults and helpers for the multi-channel VU meter driver.
package vu_pkg;

    typedef enum logic {
        VU_DIRECT = 1'b0,
        VU_DECAY  = 1'b1
    } vu_mode_e;

    localparam int VU_DEF_PWM_BITS = 7;
    localparam int VU_DEF_PWM_DIV  = 64;
    localparam int VU_PWM_PERIOD   = (1 << VU_DEF_PWM_BITS) * VU_DEF_PWM_DIV;

    // Magnitude of a w-bit two's-complement value carried sign-extended in 32 bits.
    // The most negative code saturates so the result always fits in w-1 bits.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] s, input int unsigned w);
        logic signed [31:0] most_neg;
        most_neg = -(32'sd1 <<< (w - 1));
        if (s == most_neg)
            return (32'd1 << (w - 1)) - 32'd1;
        else if (s < 0)
            return 32'(-s);
        else
            return 32'(s);
    endfunction

endpackage

// File: rtl/vu_channel.sv
// One meter channel: rectify, window-average, scale to PWM resolution and
// apply the selected ballistics. The level only moves on a completed window.
module vu_channel
    import vu_pkg::*;
#(
    parameter int SAMPLE_W    = 8,
    parameter int AVG_LOG2    = 4,
    parameter int PWM_BITS    = 7,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                audio_enable,
    input  logic                data_en,
    input  logic [SAMPLE_W-1:0] sample,
    input  vu_mode_e            mode,
    output logic [PWM_BITS-1:0] level
);

    localparam int MAG_W = SAMPLE_W - 1;
    localparam int ACC_W = MAG_W + AVG_LOG2;

    logic [MAG_W-1:0]    mag;
    logic                strobe;
    logic                last_strobe;
    logic [ACC_W-1:0]    acc_sum;

    logic [AVG_LOG2-1:0] cnt_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [PWM_BITS-1:0] target_reg;
    logic                win_done_reg;
    logic [PWM_BITS-1:0] level_reg;

    logic [PWM_BITS-1:0] diff;
    logic [PWM_BITS-1:0] level_next;

    assign mag         = MAG_W'(abs_sat(32'($signed(sample)), SAMPLE_W));
    assign strobe      = data_en && audio_enable;
    assign last_strobe = (cnt_reg == '1);
    // The window sum never exceeds 2^AVG_LOG2 full-scale magnitudes, so ACC_W bits hold it.
    assign acc_sum     = acc_reg + ACC_W'(mag);

    always_comb begin
        diff       = level_reg - target_reg;
        level_next = level_reg;
        if (win_done_reg) begin
            if (mode == VU_DIRECT || target_reg >= level_reg)
                level_next = target_reg;
            else
                level_next = level_reg - (diff >> DECAY_SHIFT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            acc_reg      <= '0;
            target_reg   <= '0;
            win_done_reg <= 1'b0;
            level_reg    <= '0;
        end else if (!audio_enable) begin
            cnt_reg      <= '0;
            acc_reg      <= '0;
            target_reg   <= '0;
            win_done_reg <= 1'b0;
            level_reg    <= '0;
        end else begin
            win_done_reg <= strobe && last_strobe;
            level_reg    <= level_next;
            if (strobe) begin
                cnt_reg <= cnt_reg + 1'b1;
                if (last_strobe) begin
                    acc_reg    <= '0;
                    // Average and scale in one step: keep the top PWM_BITS of the sum.
                    target_reg <= acc_sum[ACC_W-1 -: PWM_BITS];
                end else begin
                    acc_reg <= acc_sum;
                end
            end
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/vu_meter_multi.sv
// Multi-channel VU meter driver: per-channel level processing plus a shared
// PWM timebase whose duty registers only reload at the period boundary.
module vu_meter_multi
    import vu_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int SAMPLE_W    = 8,
    parameter int AVG_LOG2    = 4,
    parameter int PWM_BITS    = VU_DEF_PWM_BITS,
    parameter int PWM_DIV     = VU_DEF_PWM_DIV,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            data_en,
    input  logic                         audio_enable,
    input  logic [NUM_CH*SAMPLE_W-1:0]   audio_in,
    input  logic                         mode,
    input  logic                         test_en,
    input  logic [PWM_BITS-1:0]          test_level,
    output logic [NUM_CH-1:0]            vu_out,
    output logic [NUM_CH*PWM_BITS-1:0]   level_out
);

    localparam int PRESC_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PWM_BITS-1:0] level_w  [NUM_CH];
    logic [PWM_BITS-1:0] load_val [NUM_CH];
    logic [PWM_BITS-1:0] duty_reg [NUM_CH];
    logic [NUM_CH-1:0]   vu_out_reg;

    logic [PRESC_W-1:0]  presc_reg;
    logic [PWM_BITS-1:0] phase_reg;
    logic                presc_wrap;
    logic                phase_wrap;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        vu_channel #(
            .SAMPLE_W    (SAMPLE_W),
            .AVG_LOG2    (AVG_LOG2),
            .PWM_BITS    (PWM_BITS),
            .DECAY_SHIFT (DECAY_SHIFT)
        ) u_channel (
            .clk          (clk),
            .rst_n        (rst_n),
            .audio_enable (audio_enable),
            .data_en      (data_en[gi]),
            .sample       (audio_in[gi*SAMPLE_W +: SAMPLE_W]),
            .mode         (vu_mode_e'(mode)),
            .level        (level_w[gi])
        );

        assign load_val[gi]                       = test_en ? test_level : level_w[gi];
        assign level_out[gi*PWM_BITS +: PWM_BITS] = level_w[gi];
    end

    assign presc_wrap = (presc_reg == PRESC_W'(PWM_DIV - 1));
    assign phase_wrap = presc_wrap && (phase_reg == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            phase_reg <= '0;
        end else begin
            presc_reg <= presc_wrap ? '0 : presc_reg + 1'b1;
            if (presc_wrap)
                phase_reg <= phase_reg + 1'b1;
        end
    end

    // Duty only changes on the last step of a period, so every period is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++)
                duty_reg[k] <= '0;
            vu_out_reg <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (phase_wrap)
                    duty_reg[k] <= load_val[k];
                vu_out_reg[k] <= (phase_reg < duty_reg[k]);
            end
        end
    end

    assign vu_out = vu_out_reg;

endmodule

// File: tb/tb_vu_meter_multi.sv
// Directed bench for vu_meter_multi: window/ballistics vectors, PWM duty
// measurements over aligned periods, test mode, audio_enable and reset corners.
module tb_vu_meter_multi;
    import vu_pkg::*;

    localparam int NUM_CH   = 2;
    localparam int SAMPLE_W = 8;
    localparam int PWM_BITS = 7;
    localparam int PWM_DIV  = 64;
    localparam int PERIOD   = VU_PWM_PERIOD;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NUM_CH-1:0]          data_en;
    logic                       audio_enable;
    logic [NUM_CH*SAMPLE_W-1:0] audio_in;
    logic                       mode;
    logic                       test_en;
    logic [PWM_BITS-1:0]        test_level;
    logic [NUM_CH-1:0]          vu_out;
    logic [NUM_CH*PWM_BITS-1:0] level_out;

    int checks = 0;
    int errors = 0;
    int cyc;

    vu_meter_multi dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_en      (data_en),
        .audio_enable (audio_enable),
        .audio_in     (audio_in),
        .mode         (mode),
        .test_en      (test_en),
        .test_level   (test_level),
        .vu_out       (vu_out),
        .level_out    (level_out)
    );

    always #5 clk = ~clk;

    // Bench-side period tracker: interval k after reset release has cyc == k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #(10 * 120000);
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic       mode;
        logic [1:0] mask;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [6:0] e0;
        logic [6:0] e1;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic strobes(input logic [1:0] mask, input logic [7:0] s0, input logic [7:0] s1, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_en  = mask;
            audio_in = {s1, s0};
        end
        @(negedge clk);
        data_en = '0;
    endtask

    // One full window; checks the level is still old the cycle after the last
    // strobe and new one cycle later.
    task automatic run_window(input logic [1:0] mask, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [13:0] exp_before, input logic [13:0] exp_after,
                              input string name);
        strobes(mask, s0, s1, 16);
        check({name, "_hold"}, 32'(level_out), 32'(exp_before));
        @(negedge clk);
        check({name, "_lvl"}, 32'(level_out), 32'(exp_after));
    endtask

    task automatic wait_period_start(input string name, output bit found);
        found = 1'b0;
        for (int i = 0; i < PERIOD + 16 && !found; i++) begin
            @(negedge clk);
            if (cyc % PERIOD == 1) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_align: got no period start required one within %0d cycles", name, PERIOD + 16);
        end
    endtask

    task automatic measure_pwm(input int exp0, input int exp1, input string name);
        int  n0;
        int  n1;
        bit  found;
        repeat (2) @(negedge clk);
        wait_period_start(name, found);
        if (found) begin
            check({name, "_first0"}, 32'(vu_out[0]), 32'(exp0 > 0));
            check({name, "_first1"}, 32'(vu_out[1]), 32'(exp1 > 0));
            n0 = 0;
            n1 = 0;
            for (int i = 0; i < PERIOD; i++) begin
                if (i > 0) @(negedge clk);
                n0 += int'(vu_out[0]);
                n1 += int'(vu_out[1]);
            end
            check({name, "_high0"}, 32'(n0), 32'(exp0));
            check({name, "_high1"}, 32'(n1), 32'(exp1));
        end
    endtask

    initial begin
        logic [13:0] prev;
        bit          found;

        rst_n        = 1'b0;
        data_en      = '0;
        audio_enable = 1'b1;
        audio_in     = '0;
        mode         = 1'b0;
        test_en      = 1'b0;
        test_level   = '0;

        tbl[0]  = '{1'b0, 2'b11, 8'd20,  8'hD8, 7'd20,  7'd40};
        tbl[1]  = '{1'b0, 2'b11, 8'd0,   8'd0,  7'd0,   7'd0};
        tbl[2]  = '{1'b0, 2'b11, 8'd127, 8'h81, 7'd127, 7'd127};
        tbl[3]  = '{1'b1, 2'b01, 8'd0,   8'd0,  7'd112, 7'd127};
        tbl[4]  = '{1'b1, 2'b01, 8'd0,   8'd0,  7'd98,  7'd127};
        tbl[5]  = '{1'b1, 2'b01, 8'd0,   8'd0,  7'd86,  7'd127};
        tbl[6]  = '{1'b1, 2'b01, 8'd100, 8'd0,  7'd100, 7'd127};
        tbl[7]  = '{1'b1, 2'b10, 8'd0,   8'd0,  7'd100, 7'd112};
        tbl[8]  = '{1'b1, 2'b01, 8'd95,  8'd0,  7'd100, 7'd112};
        tbl[9]  = '{1'b1, 2'b01, 8'd92,  8'd0,  7'd99,  7'd112};
        tbl[10] = '{1'b0, 2'b10, 8'd0,   8'd3,  7'd99,  7'd3};
        tbl[11] = '{1'b0, 2'b01, 8'hFF,  8'd0,  7'd1,   7'd3};

        repeat (3) @(negedge clk);
        check("rst_vu_out", 32'(vu_out), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_level", 32'(level_out), 32'd0);
        check("rst_vu_after", 32'(vu_out), 32'd0);

        // Duty 64 on ch0 -> half period high; ch1 idle stays low.
        run_window(2'b01, 8'd64, 8'd0, 14'd0, {7'd0, 7'd64}, "m0_p64");
        measure_pwm(64 * PWM_DIV, 0, "pwm64");
        run_window(2'b01, 8'h80, 8'd0, {7'd0, 7'd64}, {7'd0, 7'd127}, "m0_n128");
        measure_pwm(127 * PWM_DIV, 0, "pwm127");

        prev = {7'd0, 7'd127};
        for (int i = 0; i < 12; i++) begin
            mode = tbl[i].mode;
            run_window(tbl[i].mask, tbl[i].s0, tbl[i].s1, prev, {tbl[i].e1, tbl[i].e0},
                       $sformatf("vec%0d", i));
            prev = {tbl[i].e1, tbl[i].e0};
        end

        // Mixed window on ch1: 8 x 10 and 8 x -30 averages to 20.
        mode = 1'b0;
        strobes(2'b10, 8'd0, 8'd10, 8);
        strobes(2'b10, 8'd0, 8'hE2, 8);
        check("mixed_hold", 32'(level_out), 32'({7'd3, 7'd1}));
        @(negedge clk);
        check("mixed_lvl", 32'(level_out), 32'({7'd20, 7'd1}));

        test_level = 7'd32;
        test_en    = 1'b1;
        measure_pwm(32 * PWM_DIV, 32 * PWM_DIV, "test32");
        run_window(2'b01, 8'd64, 8'd0, {7'd20, 7'd1}, {7'd20, 7'd64}, "test_track");
        test_en = 1'b0;

        @(negedge clk);
        audio_enable = 1'b0;
        @(negedge clk);
        check("ae_clear", 32'(level_out), 32'd0);
        audio_enable = 1'b1;
        strobes(2'b01, 8'd50, 8'd0, 8);
        audio_enable = 1'b0;
        data_en      = 2'b01;
        audio_in     = {8'd0, 8'd100};
        @(negedge clk);
        data_en      = '0;
        @(negedge clk);
        audio_enable = 1'b1;
        strobes(2'b01, 8'd100, 8'd0, 15);
        @(negedge clk);
        check("ae_partial", 32'(level_out), 32'd0);
        strobes(2'b01, 8'd100, 8'd0, 1);
        check("ae_hold", 32'(level_out), 32'd0);
        @(negedge clk);
        check("ae_full", 32'(level_out), 32'({7'd0, 7'd100}));

        // Asynchronous reset in the middle of a fully driven period.
        test_level = 7'd127;
        test_en    = 1'b1;
        repeat (2) @(negedge clk);
        wait_period_start("rst_mid", found);
        wait_period_start("rst_mid2", found);
        repeat (3000) @(negedge clk);
        check("pre_rst_high", 32'(vu_out), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_vu", 32'(vu_out), 32'd0);
        check("rst_async_lvl", 32'(level_out), 32'd0);
        test_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_vu", 32'(vu_out), 32'd0);
        run_window(2'b01, 8'd64, 8'd0, 14'd0, {7'd0, 7'd64}, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
